// File: rtl/regfile_write_arbiter.sv
// Register-file write port arbiter.
// Producer A (writeback) and producer B (multdiv) share one regfile write port.
// A has default priority; a starvation counter hands priority to B once it has
// been blocked long enough. A 32-bit busy scoreboard tracks registers with a
// multdiv result still outstanding so issue logic can stall on RAW hazards.
module regfile_write_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = 32
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [4:0]        a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [4:0]        b_reg,
  input  logic [DATA_W-1:0] b_data,
  input  logic              claim_valid,
  input  logic [4:0]        claim_reg,
  output logic [31:0]       busy_vec,
  output logic              ctrl_writeEnable,
  output logic [4:0]        ctrl_writeReg,
  output logic [DATA_W-1:0] data_writeReg
);

  localparam logic [0:0] PRIO_A = 1'b0;
  localparam logic [0:0] PRIO_B = 1'b1;

  localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
  localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

  logic [0:0] state_reg;
  logic [0:0] state_next;
  logic [3:0] starve_cnt_reg;
  logic [3:0] starve_cnt_next;

  logic a_xfer;
  logic b_xfer;
  logic b_blocked;

  // Ready outputs: the priority holder is always ready, the other only when
  // the priority holder is not requesting, so at most one transfer per cycle.
  always_comb begin
    a_ready = 1'b1;
    b_ready = 1'b1;
    if (state_reg == PRIO_A) begin
      b_ready = !a_valid;
    end else begin
      a_ready = !b_valid;
    end
  end

  assign a_xfer    = a_valid && a_ready;
  assign b_xfer    = b_valid && b_ready;
  assign b_blocked = b_valid && !b_ready;

  // Starvation count and priority state next-value logic.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (b_xfer || !b_valid) begin
      starve_cnt_next = 4'd0;
    end else if (starve_cnt_reg < LIMIT) begin
      starve_cnt_next = starve_cnt_reg + 4'd1;
    end

    state_next = state_reg;
    if (state_reg == PRIO_A) begin
      if (b_blocked && (starve_cnt_reg == LIMIT_M1)) begin
        state_next = PRIO_B;
      end
    end else begin
      // Leave B priority on its transfer, or recover if B withdrew its request.
      if (b_xfer || !b_valid) begin
        state_next = PRIO_A;
      end
    end
  end

  // Priority state and starvation counter registers.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_reg      <= PRIO_A;
      starve_cnt_reg <= 4'd0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // Registered regfile write port: one-cycle latency, reg 0 never enabled,
  // address/data hold when nothing transfers.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= 5'd0;
      data_writeReg    <= '0;
    end else if (a_xfer) begin
      ctrl_writeEnable <= (a_reg != 5'd0);
      ctrl_writeReg    <= a_reg;
      data_writeReg    <= a_data;
    end else if (b_xfer) begin
      ctrl_writeEnable <= (b_reg != 5'd0);
      ctrl_writeReg    <= b_reg;
      data_writeReg    <= b_data;
    end else begin
      ctrl_writeEnable <= 1'b0;
    end
  end

  // Bit 0 of the scoreboard is hardwired clear: reg 0 can never be pending.
  assign busy_vec[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
      logic set_bit;
      logic clr_bit;
      assign set_bit = claim_valid && (claim_reg == 5'(gi));
      assign clr_bit = b_xfer && (b_reg == 5'(gi));

      // Per-register busy flag: a claim sets it, a B result clears it, set wins.
      always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
          busy_vec[gi] <= 1'b0;
        end else if (set_bit) begin
          busy_vec[gi] <= 1'b1;
        end else if (clr_bit) begin
          busy_vec[gi] <= 1'b0;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed testbench for regfile_write_arbiter (STARVE_LIMIT=4, DATA_W=32).
// Inputs change 1ns after the rising edge; ready outputs are checked 1ns
// later, registered outputs 1ns after the edge that loads them.
module tb_regfile_write_arbiter;

  logic        clock;
  logic        ctrl_reset_n;
  logic        a_valid;
  logic        a_ready;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic        claim_valid;
  logic [4:0]  claim_reg;
  logic [31:0] busy_vec;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  int checks;
  int failures;

  regfile_write_arbiter #(
    .STARVE_LIMIT(4),
    .DATA_W(32)
  ) dut (
    .clock(clock),
    .ctrl_reset_n(ctrl_reset_n),
    .a_valid(a_valid),
    .a_ready(a_ready),
    .a_reg(a_reg),
    .a_data(a_data),
    .b_valid(b_valid),
    .b_ready(b_ready),
    .b_reg(b_reg),
    .b_data(b_data),
    .claim_valid(claim_valid),
    .claim_reg(claim_reg),
    .busy_vec(busy_vec),
    .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_write(input string tag, input logic we, input logic [4:0] r, input logic [31:0] d);
    check({tag, ".we"},   32'(ctrl_writeEnable), 32'(we));
    check({tag, ".reg"},  32'(ctrl_writeReg),    32'(r));
    check({tag, ".data"}, data_writeReg,         d);
  endtask

  // Both producers requesting with A streaming: B must be blocked for four
  // cycles and win on the fifth, then its write appears one cycle later.
  task automatic starve_run(input string tag, input logic [4:0] br, input logic [31:0] bd);
    a_valid = 1'b1; a_reg = 5'd4; a_data = 32'h0000_0A00;
    b_valid = 1'b1; b_reg = br;   b_data = bd;
    for (int c = 1; c <= 4; c++) begin
      #1;
      check($sformatf("%s.c%0d.b_ready", tag, c), 32'(b_ready), 32'd0);
      check($sformatf("%s.c%0d.a_ready", tag, c), 32'(a_ready), 32'd1);
      tick();
      check($sformatf("%s.c%0d.a_write_data", tag, c), data_writeReg, 32'h0000_0A00);
    end
    #1;
    check({tag, ".c5.b_ready"}, 32'(b_ready), 32'd1);
    check({tag, ".c5.a_ready"}, 32'(a_ready), 32'd0);
    tick();
    check_write({tag, ".b_write"}, 1'b1, br, bd);
    b_valid = 1'b0;
    #1;
    check({tag, ".back_to_a"}, 32'(a_ready), 32'd1);
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    check({tag, ".prio_a_b_ready"}, 32'(b_ready), 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    ctrl_reset_n = 1'b0;
    a_valid = 1'b0; a_reg = 5'd0; a_data = 32'd0;
    b_valid = 1'b0; b_reg = 5'd0; b_data = 32'd0;
    claim_valid = 1'b0; claim_reg = 5'd0;

    // Reset values
    tick();
    tick();
    check_write("reset", 1'b0, 5'd0, 32'd0);
    check("reset.busy", busy_vec, 32'd0);
    ctrl_reset_n = 1'b1;
    tick();

    // A only
    a_valid = 1'b1; a_reg = 5'd3; a_data = 32'hDEAD_BEEF;
    #1;
    check("a_only.a_ready", 32'(a_ready), 32'd1);
    tick();
    check_write("a_only", 1'b1, 5'd3, 32'hDEAD_BEEF);
    a_valid = 1'b0;
    tick();
    check_write("idle_hold", 1'b0, 5'd3, 32'hDEAD_BEEF);

    // Same-cycle A and B to reg 31: A wins, B retries next cycle
    a_valid = 1'b1; a_reg = 5'd31; a_data = 32'h1234_5678;
    b_valid = 1'b1; b_reg = 5'd31; b_data = 32'h0000_AAAA;
    #1;
    check("same_reg.a_ready", 32'(a_ready), 32'd1);
    check("same_reg.b_ready", 32'(b_ready), 32'd0);
    tick();
    check_write("same_reg.a_win", 1'b1, 5'd31, 32'h1234_5678);
    a_valid = 1'b0;
    #1;
    check("same_reg.b_retry_ready", 32'(b_ready), 32'd1);
    tick();
    check_write("same_reg.b_write", 1'b1, 5'd31, 32'h0000_AAAA);
    b_valid = 1'b0;
    tick();

    // Starvation with STARVE_LIMIT=4
    starve_run("starve", 5'd7, 32'h0000_0055);

    // B idle while A streams for 10 cycles; counter must not advance
    b_valid = 1'b0;
    a_valid = 1'b1; a_reg = 5'd2;
    for (int i = 0; i < 10; i++) begin
      a_data = 32'h100 + 32'(i);
      tick();
      check($sformatf("idle_b.stream%0d", i), data_writeReg, 32'h100 + 32'(i));
    end
    starve_run("after_idle", 5'd8, 32'h0000_0088);

    // Scoreboard
    claim_valid = 1'b1; claim_reg = 5'd9;
    tick();
    claim_valid = 1'b0;
    check("sb.claim9", busy_vec, 32'h0000_0200);
    b_valid = 1'b1; b_reg = 5'd9; b_data = 32'h0000_0099;
    #1;
    check("sb.b_ready", 32'(b_ready), 32'd1);
    tick();
    b_valid = 1'b0;
    check("sb.clear9", busy_vec, 32'd0);
    check_write("sb.b_write", 1'b1, 5'd9, 32'h0000_0099);
    claim_valid = 1'b1; claim_reg = 5'd9;
    tick();
    b_valid = 1'b1; b_reg = 5'd9;
    tick();
    claim_valid = 1'b0; b_valid = 1'b0;
    check("sb.set_wins", busy_vec, 32'h0000_0200);
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    check("sb.clear_again", busy_vec, 32'd0);
    claim_valid = 1'b1; claim_reg = 5'd5;
    tick();
    claim_reg = 5'd20;
    tick();
    claim_valid = 1'b0;
    check("sb.two_bits", busy_vec, 32'h0010_0020);
    a_valid = 1'b1; a_reg = 5'd20; a_data = 32'h0;
    tick();
    a_valid = 1'b0;
    check("sb.a_no_clear", busy_vec, 32'h0010_0020);
    b_valid = 1'b1; b_reg = 5'd5;
    tick();
    b_valid = 1'b0;
    check("sb.clear5", busy_vec, 32'h0010_0000);

    // Reg 0
    a_valid = 1'b1; a_reg = 5'd0; a_data = 32'h0000_0001;
    #1;
    check("reg0.a_ready", 32'(a_ready), 32'd1);
    tick();
    a_valid = 1'b0;
    check("reg0.we", 32'(ctrl_writeEnable), 32'd0);
    claim_valid = 1'b1; claim_reg = 5'd0;
    tick();
    claim_valid = 1'b0;
    check("reg0.claim", busy_vec, 32'h0010_0000);

    // Mid-stream reset drops the accepted write and clears everything
    a_valid = 1'b1; a_reg = 5'd12; a_data = 32'hCAFE_0012;
    tick();
    check_write("pre_reset", 1'b1, 5'd12, 32'hCAFE_0012);
    a_reg = 5'd13; a_data = 32'hCAFE_0013;
    #2;
    ctrl_reset_n = 1'b0;
    #1;
    check_write("mid_reset", 1'b0, 5'd0, 32'd0);
    check("mid_reset.busy", busy_vec, 32'd0);
    tick();
    check_write("reset_drop", 1'b0, 5'd0, 32'd0);
    a_valid = 1'b0;
    ctrl_reset_n = 1'b1;
    tick();
    check("post_reset.we", 32'(ctrl_writeEnable), 32'd0);
    a_valid = 1'b1; b_valid = 1'b1; b_reg = 5'd1;
    #1;
    check("post_reset.prio_a", 32'(b_ready), 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
